// File: rtl/mips_ctrl_pkg.sv
// Shared control-path definitions for the MIPS pipeline: interrupt FSM
// encodings, PC-source codes and the kernel-mode PC bit.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TAKE    = 2'd2,
        ST_HANDLER = 2'd3
    } irq_state_t;

    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JR     = 3'b011;
    localparam int         KERNEL_BIT   = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module irq_prio_enc #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
) (
    input  logic [N_SRC-1:0]   req,
    output logic               valid,
    output logic [CAUSE_W-1:0] index,
    output logic [N_SRC-1:0]   onehot
);

    // Scan from the top down so the lowest index overwrites any higher one.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid     = 1'b1;
                index     = CAUSE_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: captures source edges, waits for a safe pipeline point,
// issues a one-cycle take with EPC/cause, and masks until eret.
module irq_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_irq,
    input  logic               ie,
    input  logic [31:0]        ifid_pc,
    input  logic [2:0]         ifid_pcsrc,
    input  logic               idex_jump,
    input  logic               stall,
    input  logic               ifid_eret,
    output logic               irq,
    output logic               epc_wr,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic [N_SRC-1:0]   irq_ack,
    output logic               in_handler
);

    irq_state_t         state;
    irq_state_t         state_nxt;
    logic [N_SRC-1:0]   src_q;
    logic               src_armed;
    logic [N_SRC-1:0]   pend;
    logic [N_SRC-1:0]   edges;
    logic [31:0]        epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [N_SRC-1:0]   ack_q;
    logic               win_valid;
    logic [CAUSE_W-1:0] win_idx;
    logic [N_SRC-1:0]   win_onehot;
    logic               safe;

    irq_prio_enc #(
        .N_SRC  (N_SRC),
        .CAUSE_W(CAUSE_W)
    ) u_prio (
        .req   (pend),
        .valid (win_valid),
        .index (win_idx),
        .onehot(win_onehot)
    );

    // src_armed stays low for the first cycle after reset so a level that is
    // already high at release is absorbed into src_q instead of seen as an edge.
    assign edges = src_irq & ~src_q & {N_SRC{src_armed}};

    assign safe = !stall && !idex_jump &&
                  (ifid_pcsrc != PCSRC_BRANCH) && (ifid_pcsrc != PCSRC_JR) &&
                  !ifid_pc[KERNEL_BIT];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ie && win_valid) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!ie || !win_valid) state_nxt = ST_IDLE;
                else if (safe)         state_nxt = ST_TAKE;
            end
            ST_TAKE: begin
                state_nxt = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (ifid_eret) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            src_q     <= '0;
            src_armed <= 1'b0;
            pend      <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            ack_q     <= '0;
        end else begin
            state     <= state_nxt;
            src_q     <= src_irq;
            src_armed <= 1'b1;
            // OR-ing edges after the clear lets a fresh edge survive its own ack.
            pend      <= (pend & ~ack_q) | edges;
            if (state == ST_WAIT && state_nxt == ST_TAKE) begin
                epc_q   <= ifid_pc;
                cause_q <= win_idx;
                ack_q   <= win_onehot;
            end else begin
                ack_q   <= '0;
            end
        end
    end

    assign irq        = (state == ST_TAKE);
    assign epc_wr     = (state == ST_TAKE);
    assign irq_ack    = ack_q;
    assign in_handler = (state == ST_HANDLER);
    assign epc        = epc_q;
    assign cause      = cause_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scenario bench for irq_sequencer: expected takes are queued as stimulus is
// driven and checked by a negedge monitor when irq fires.
module tb_irq_sequencer;
    import mips_ctrl_pkg::*;

    localparam int N_SRC   = 4;
    localparam int CAUSE_W = 3;
    localparam int EXP_W   = 32 + 32 + CAUSE_W + N_SRC;
    localparam logic [31:0] USER_PC = 32'h0040_0010;

    logic               clk;
    logic               reset;
    logic [N_SRC-1:0]   src_irq;
    logic               ie;
    logic [31:0]        ifid_pc;
    logic [2:0]         ifid_pcsrc;
    logic               idex_jump;
    logic               stall;
    logic               ifid_eret;
    logic               irq;
    logic               epc_wr;
    logic [31:0]        epc;
    logic [CAUSE_W-1:0] cause;
    logic [N_SRC-1:0]   irq_ack;
    logic               in_handler;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_irq = 1'b0;
    logic [EXP_W-1:0] exp_q[$];

    irq_sequencer #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq), .ie(ie),
        .ifid_pc(ifid_pc), .ifid_pcsrc(ifid_pcsrc), .idex_jump(idex_jump),
        .stall(stall), .ifid_eret(ifid_eret), .irq(irq), .epc_wr(epc_wr),
        .epc(epc), .cause(cause), .irq_ack(irq_ack), .in_handler(in_handler)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected take: cycle (0 = any), epc, cause, one-hot ack.
    function automatic logic [EXP_W-1:0] mk_exp(input int c, input logic [31:0] pc, input int idx);
        logic [N_SRC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return {c[31:0], pc, idx[CAUSE_W-1:0], oh};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0]   e;
        logic [31:0]        e_cyc;
        logic [31:0]        e_pc;
        logic [CAUSE_W-1:0] e_cause;
        logic [N_SRC-1:0]   e_ack;
        if (reset) begin
            checks++;
            if (epc_wr !== irq || ((irq_ack != '0) !== irq)) begin
                errors++;
                $display("FAIL strobes cycle %0d irq %b epc_wr %b irq_ack %b", cyc, irq, epc_wr, irq_ack);
            end
            if (irq === 1'b1) begin
                checks++;
                if (prev_irq || in_handler) begin
                    errors++;
                    $display("FAIL irq_pulse cycle %0d prev_irq %b in_handler %b required 0 0", cyc, prev_irq, in_handler);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_irq cycle %0d cause %0d epc %h", cyc, cause, epc);
                end else begin
                    e       = exp_q.pop_front();
                    e_cyc   = e[EXP_W-1 -: 32];
                    e_pc    = e[EXP_W-33 -: 32];
                    e_cause = e[N_SRC+CAUSE_W-1 -: CAUSE_W];
                    e_ack   = e[N_SRC-1:0];
                    if (epc !== e_pc || cause !== e_cause || irq_ack !== e_ack) begin
                        errors++;
                        $display("FAIL take_values cycle %0d epc %h cause %0d ack %b required epc %h cause %0d ack %b",
                                 cyc, epc, cause, irq_ack, e_pc, e_cause, e_ack);
                    end
                    if (e_cyc != 0) begin
                        checks++;
                        if (cyc != e_cyc) begin
                            errors++;
                            $display("FAIL take_cycle got %0d required %0d", cyc, e_cyc);
                        end
                    end
                end
            end
            prev_irq = irq;
        end else begin
            prev_irq = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input bit auto_eret);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            ifid_eret = auto_eret && in_handler;
            n++;
        end
        ifid_eret = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic leave_handler();
        checks++;
        if (in_handler !== 1'b1) begin
            errors++;
            $display("FAIL in_handler_after_take got %b required 1", in_handler);
        end
        ifid_eret = 1'b1;
        tick();
        ifid_eret = 1'b0;
        @(negedge clk);
        checks++;
        if (in_handler !== 1'b0) begin
            errors++;
            $display("FAIL in_handler_after_eret got %b required 0", in_handler);
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; src_irq = 4'b1000; ie = 1'b1; ifid_pc = USER_PC;
        ifid_pcsrc = 3'b000; idex_jump = 1'b0; stall = 1'b0; ifid_eret = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (irq !== 0 || epc_wr !== 0 || epc !== 0 || cause !== 0 || irq_ack !== 0 || in_handler !== 0) begin
            errors++;
            $display("FAIL reset_outputs irq %b epc_wr %b epc %h cause %0d ack %b inh %b required all 0",
                     irq, epc_wr, epc, cause, irq_ack, in_handler);
        end
        reset = 1'b1;
        repeat (6) tick();
        src_irq = '0;
        tick();
    endtask

    task automatic test_basic_take();
        src_irq[2] = 1'b1;
        exp_q.push_back(mk_exp(cyc + 3, USER_PC, 2));
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    task automatic test_priority();
        src_irq[3] = 1'b1;
        src_irq[1] = 1'b1;
        exp_q.push_back(mk_exp(0, USER_PC, 1));
        exp_q.push_back(mk_exp(0, USER_PC, 3));
        drain(20, 1'b1);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    task automatic test_unsafe_deferral();
        logic [31:0] pc_take;
        for (int s = 0; s < 8; s++) begin
            ifid_pc    = 32'h0040_0200 + 32'(s * 4);
            stall      = (s < 5);
            ifid_pcsrc = (s == 5) ? PCSRC_BRANCH : 3'b000;
            idex_jump  = (s == 6);
            if (s == 0) src_irq[1] = 1'b1;
            if (s == 7) begin
                pc_take = ifid_pc;
                exp_q.push_back(mk_exp(cyc + 1, pc_take, 1));
            end
            tick();
        end
        ifid_pc = 32'h0040_0300;
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    task automatic test_mask_kernel();
        ifid_pc    = 32'h8000_0100;
        src_irq[0] = 1'b1;
        repeat (8) tick();
        checks++;
        if (in_handler !== 1'b0) begin
            errors++;
            $display("FAIL kernel_block in_handler %b required 0", in_handler);
        end
        ifid_pc = 32'h0040_0100;
        exp_q.push_back(mk_exp(0, 32'h0040_0100, 0));
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
        // ie dropped while waiting: back to IDLE, pend retained.
        ifid_pc    = 32'h8000_0000;
        src_irq[2] = 1'b1;
        tick(); tick();
        ie = 1'b0;
        repeat (6) tick();
        ifid_pc = 32'h0040_0400;
        repeat (4) tick();
        ie = 1'b1;
        exp_q.push_back(mk_exp(cyc + 2, 32'h0040_0400, 2));
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    task automatic test_nesting_block();
        ifid_pc    = USER_PC;
        src_irq[3] = 1'b1;
        exp_q.push_back(mk_exp(0, USER_PC, 3));
        drain(10, 1'b0);
        src_irq[0] = 1'b1;
        repeat (6) tick();
        checks++;
        if (in_handler !== 1'b1) begin
            errors++;
            $display("FAIL nest_hold in_handler %b required 1", in_handler);
        end
        ifid_pc   = 32'h0040_0500;
        ifid_eret = 1'b1;
        exp_q.push_back(mk_exp(cyc + 3, 32'h0040_0500, 0));
        tick();
        ifid_eret = 1'b0;
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset while waiting on a kernel-mode PC.
        ifid_pc    = 32'h8000_0000;
        src_irq[1] = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (irq !== 0 || epc_wr !== 0 || epc !== 0 || cause !== 0 || irq_ack !== 0 || in_handler !== 0) begin
            errors++;
            $display("FAIL reset_in_wait irq %b epc %h cause %0d ack %b inh %b required all 0",
                     irq, epc, cause, irq_ack, in_handler);
        end
        reset   = 1'b1;
        ifid_pc = USER_PC;
        repeat (8) tick();
        // Reset inside the handler.
        src_irq[2] = 1'b1;
        exp_q.push_back(mk_exp(0, USER_PC, 2));
        drain(10, 1'b0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (irq !== 0 || epc_wr !== 0 || epc !== 0 || cause !== 0 || irq_ack !== 0 || in_handler !== 0) begin
            errors++;
            $display("FAIL reset_in_handler irq %b epc %h cause %0d ack %b inh %b required all 0",
                     irq, epc, cause, irq_ack, in_handler);
        end
        reset = 1'b1;
        repeat (8) tick();
        checks++;
        if (in_handler !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle in_handler %b required 0", in_handler);
        end
        // Recovery: a genuine new edge is still taken.
        src_irq = '0;
        tick();
        src_irq[0] = 1'b1;
        exp_q.push_back(mk_exp(cyc + 3, USER_PC, 0));
        drain(10, 1'b0);
        leave_handler();
        src_irq = '0;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_take();
        test_priority();
        test_unsafe_deferral();
        test_mask_kernel();
        test_nesting_block();
        test_reset_mid();
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
